// File: rtl/result_bus_arbiter_if.sv
// rtl/result_bus_arbiter_if.sv - execution-unit result bus and operand/GPR broadcast bundle
interface result_bus_arbiter_if #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
);

  // CR0/XER side result produced alongside each execution-unit result
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ca;
    logic ov32;
  } cond_exception_t;

  // producer side, one lane per execution unit
  logic            [0:UNITS-1]                   unit_valid;
  logic            [0:UNITS-1]                   unit_ready;
  logic            [0:UNITS-1][0:RS_ID_WIDTH-1]  unit_rs_id;
  logic            [0:UNITS-1][0:4]              unit_reg_addr;
  logic            [0:UNITS-1][0:31]             unit_result;
  cond_exception_t [0:UNITS-1]                   unit_cr0_xer;
  logic            [0:UNITS-1][0:31]             unit_xer_value;
  logic            [0:UNITS-1]                   unit_xer_write;

  // broadcast side toward reservation stations and the register file
  logic                     update_op_valid;
  logic [0:RS_ID_WIDTH-1]   update_op_rs_id;
  logic [0:31]              update_op_value;
  logic                     update_xer_valid;
  logic [0:RS_ID_WIDTH-1]   update_xer_rs_id;
  logic [0:31]              update_xer_value;
  logic                     gpr_we;
  logic [0:4]               gpr_waddr;
  logic [0:31]              gpr_wdata;
  logic                     cr0_xer_valid;
  cond_exception_t          cr0_xer_out;

  modport master (
    output unit_valid, unit_rs_id, unit_reg_addr, unit_result,
           unit_cr0_xer, unit_xer_value, unit_xer_write,
    input  unit_ready,
    input  update_op_valid, update_op_rs_id, update_op_value,
           update_xer_valid, update_xer_rs_id, update_xer_value,
           gpr_we, gpr_waddr, gpr_wdata, cr0_xer_valid, cr0_xer_out
  );

  modport slave (
    input  unit_valid, unit_rs_id, unit_reg_addr, unit_result,
           unit_cr0_xer, unit_xer_value, unit_xer_write,
    output unit_ready,
    output update_op_valid, update_op_rs_id, update_op_value,
           update_xer_valid, update_xer_rs_id, update_xer_value,
           gpr_we, gpr_waddr, gpr_wdata, cr0_xer_valid, cr0_xer_out
  );

endinterface

// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - round-robin result collector driving the one-cycle operand/GPR broadcast
module result_bus_arbiter #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  result_bus_arbiter_if.slave  bus
);

  localparam int PTR_W = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int CX_W  = 7;

  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_grant_idx;
  logic [PTR_W-1:0]       w_cand;
  logic [PTR_W:0]         w_sum;
  logic                   w_grant_found;
  logic                   w_xfer;
  logic [0:UNITS-1]       w_unit_ready;

  logic                   r_valid;
  logic                   r_xer_valid;
  logic [0:RS_ID_WIDTH-1] r_rs_id;
  logic [0:4]             r_reg_addr;
  logic [0:31]            r_result;
  logic [0:31]            r_xer_value;
  logic [CX_W-1:0]        r_cr0_xer;

  // round-robin search: first valid unit at or after the pointer, wrapping around
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    w_sum         = '0;
    for (int k = 0; k < UNITS; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(UNITS)) begin
        w_sum = w_sum - (PTR_W+1)'(UNITS);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_grant_found && bus.unit_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // ready is withheld during reset so nothing is consumed while state is being cleared
  assign w_xfer = w_grant_found & ~rst;

  // one-hot accept on the winner only
  always_comb begin
    w_unit_ready = '0;
    if (w_xfer) begin
      w_unit_ready[w_grant_idx] = 1'b1;
    end
  end

  assign bus.unit_ready = w_unit_ready;

  // capture the winner's result and advance the pointer past it; valids are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_valid     <= 1'b0;
      r_xer_valid <= 1'b0;
      r_rs_id     <= '0;
      r_reg_addr  <= '0;
      r_result    <= '0;
      r_xer_value <= '0;
      r_cr0_xer   <= '0;
    end else begin
      r_valid     <= w_xfer;
      r_xer_valid <= w_xfer & bus.unit_xer_write[w_grant_idx];
      if (w_xfer) begin
        r_rs_id     <= bus.unit_rs_id[w_grant_idx];
        r_reg_addr  <= bus.unit_reg_addr[w_grant_idx];
        r_result    <= bus.unit_result[w_grant_idx];
        r_xer_value <= bus.unit_xer_value[w_grant_idx];
        r_cr0_xer   <= bus.unit_cr0_xer[w_grant_idx];
        if (w_grant_idx == PTR_W'(UNITS-1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_grant_idx + PTR_W'(1);
        end
      end
    end
  end

  assign bus.update_op_valid  = r_valid;
  assign bus.update_op_rs_id  = r_rs_id;
  assign bus.update_op_value  = r_result;
  assign bus.update_xer_valid = r_xer_valid;
  assign bus.update_xer_rs_id = r_rs_id;
  assign bus.update_xer_value = r_xer_value;
  assign bus.gpr_we           = r_valid;
  assign bus.gpr_waddr        = r_reg_addr;
  assign bus.gpr_wdata        = r_result;
  assign bus.cr0_xer_valid    = r_valid;
  assign bus.cr0_xer_out      = r_cr0_xer;

endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Consumer end of the execution-unit result interface: collects ready-valid results (rs_id, result_reg_addr, result, cr0_xer) from up to UNITS execution wrappers (rot, add, logic, ...).
- Arbitrates round-robin and drives the single-cycle broadcast (update_op_valid / update_op_rs_id_in / update_op_value_in, plus XER update) that feeds every reservation station's operand-update port.
- Drives the GPR write port in the same cycle as the broadcast.

Parameters:
UNITS, 4, number of result-producing execution units (2..8)
RS_ID_WIDTH, 5, width of reservation-station ids

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
unit_valid  input  [0:UNITS-1]  per-unit result valid
unit_ready  output  [0:UNITS-1]  per-unit accept (one-hot or zero)
unit_rs_id  input  [0:UNITS-1][0:RS_ID_WIDTH-1]  producing RS id
unit_reg_addr  input  [0:UNITS-1][0:4]  destination GPR
unit_result  input  [0:UNITS-1][0:31]  result value
unit_cr0_xer  input  [0:UNITS-1] cond_exception_t  CR0/XER side result
unit_xer_value  input  [0:UNITS-1][0:31]  updated XER value
unit_xer_write  input  [0:UNITS-1]  result also updates XER
update_op_valid  output  1  GPR operand broadcast valid
update_op_rs_id  output  RS_ID_WIDTH  broadcast RS id
update_op_value  output  32  broadcast value
update_xer_valid  output  1  XER broadcast valid
update_xer_rs_id  output  RS_ID_WIDTH  XER broadcast RS id
update_xer_value  output  32  XER broadcast value
gpr_we  output  1  register-file write enable
gpr_waddr  output  5  register-file write address
gpr_wdata  output  32  register-file write data
cr0_xer_valid  output  1  cr0_xer_out valid
cr0_xer_out  output  cond_exception_t  CR0/XER side result

Behaviour:
- Reset: all broadcast and write outputs 0 (valids, ids, values, addresses, cr0_xer_out); round-robin pointer = 0; unit_ready = 0 while rst is high.
- Grant: combinational. Search unit_valid starting at the pointer with wrap-around; the first set bit wins. unit_ready is one-hot on the winner, all zero when no unit is valid.
  - unit_ready[i] may depend on unit_valid (producers must not gate valid on ready).
  - A transfer occurs when unit_valid[i] & unit_ready[i]. At most one per cycle.
- Pointer: on a transfer from unit i, pointer <= (i+1) mod UNITS. It is unchanged when there is no transfer. Wrap: a grant of UNITS-1 sets pointer 0.
- Latency: fixed 1 cycle. Accepted data is registered; on the next edge update_op_valid, gpr_we and cr0_xer_valid are 1.
  - update_op_rs_id and update_op_value take the registered rs_id and result.
  - gpr_waddr takes reg_addr; gpr_wdata takes result; cr0_xer_out takes the cr0_xer.
- update_xer_valid = registered unit_xer_write. update_xer_rs_id = the same rs_id. update_xer_value = the unit's xer value.
- Broadcast has no back-pressure: every valid is a one-cycle pulse, and a new transfer can occur every cycle (full throughput, back-to-back pulses).
- No transfer in a cycle: all valid outputs drop to 0 the next cycle. Data outputs hold their last values (don't-care while valid is low).
- Simultaneous: if all units are valid every cycle, grants rotate 0,1,..,UNITS-1,0. No unit is starved for more than UNITS-1 cycles.
- Reset mid-operation: the in-flight registered result is discarded and outputs clear immediately (async). The pointer returns to 0.
- Outputs are purely registered, except unit_ready.

Test Plan:
- Reset then idle: rst pulse mid-run with a broadcast pending -> all valids 0 immediately, unit_ready=0; after release with no valid inputs -> outputs stay 0.
- Single transfer: unit 2 valid with rs_id=5'h0A, reg_addr=3, result=32'hDEADBEEF, xer_write=0 -> unit_ready=4'b0010 (bit 2); next cycle update_op_valid=1, rs_id=0A, value=DEADBEEF, gpr_we=1, waddr=3, update_xer_valid=0; the cycle after, all valids 0.
- Round-robin fairness: all 4 units held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 consecutive broadcast pulses with the matching rs_ids.
- Pointer wrap and skip: pointer=3, only units 1 and 3 valid -> unit 3 granted, then unit 1 (pointer wrapped to 0); unit 1 has no further grant until it re-asserts valid.
- XER path: unit 0 valid with xer_write=1, xer_value=32'h2000_0000, rs_id=5'h11 -> next cycle update_xer_valid=1, update_xer_value=20000000, update_xer_rs_id=11, together with update_op_valid=1.
- Producer held off: unit 1 valid while unit 0 is granted -> unit_ready[1]=0; unit 1 keeps its data stable and is granted the next cycle with its original values broadcast.
